// File: rtl/alu_pkg.sv
// Shared opcode constants for the behavioral_alu datapath leaf and its bench.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU core: eight unsigned operations plus carry/borrow/shifted-out bit.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  operation,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Widened add/subtract; bit WIDTH of the difference is the borrow.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
    end

    // Opcode decode; single-operand ops never reference b.
    always_comb begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        case (operation)
            OP_ADD: begin
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            OP_SUB: begin
                result = diff_s[WIDTH-1:0];
                carry  = diff_s[WIDTH];
            end
            OP_AND: begin
                result = a & b;
                carry  = 1'b0;
            end
            OP_OR: begin
                result = a | b;
                carry  = 1'b0;
            end
            OP_XOR: begin
                result = a ^ b;
                carry  = 1'b0;
            end
            OP_NOT: begin
                result = ~a;
                carry  = 1'b0;
            end
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: begin
                result = {WIDTH{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

endmodule : alu_core

// File: rtl/behavioral_alu.sv
// Registered ALU: alu_core followed by a one-cycle output register with synchronous reset.
module behavioral_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  operation,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (a),
        .b         (b),
        .operation (operation),
        .result    (result_d),
        .carry     (carry_d)
    );

    // Output register; reset takes priority over whatever the core computes.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;

endmodule : behavioral_alu

// File: tb/tb_behavioral_alu.sv
// Self-checking bench for behavioral_alu: directed corner cases plus randomized
// back-to-back vectors against an arithmetic reference model.
module tb_behavioral_alu;
    import alu_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic          clk;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OP_W-1:0] operation;
    logic [W-1:0]  result;
    logic          carry_out;

    int checks;
    int errors;

    behavioral_alu #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .operation (operation),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode's meaning.
    task automatic ref_model(input int ra, input int rb, input int op,
                             output int res, output int cy);
        case (op)
            0: begin res = (ra + rb) % MOD;        cy = ((ra + rb) >= MOD) ? 1 : 0; end
            1: begin res = (ra - rb + MOD) % MOD;  cy = (ra < rb) ? 1 : 0; end
            2: begin res = ra & rb;                cy = 0; end
            3: begin res = ra | rb;                cy = 0; end
            4: begin res = ra ^ rb;                cy = 0; end
            5: begin res = (MOD - 1) - ra;         cy = 0; end
            6: begin res = (ra * 2) % MOD;         cy = (ra >= MOD / 2) ? 1 : 0; end
            default: begin res = ra / 2;           cy = ra % 2; end
        endcase
    endtask

    // Drive one vector, let one edge pass, then check result and carry.
    task automatic apply(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [OP_W-1:0] vop, input int exp_r, input int exp_c);
        a = va;
        b = vb;
        operation = vop;
        @(posedge clk);
        #1;
        check_val({tag, "_res"}, 32'(result), 32'(exp_r));
        check_val({tag, "_cy"},  32'(carry_out), 32'(exp_c));
    endtask

    initial begin
        int er;
        int ec;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [OP_W-1:0] rop;

        checks = 0;
        errors = 0;

        rst = 1'b1;
        a = 4'hF;
        b = 4'hF;
        operation = OP_ADD;
        @(posedge clk);
        #1;
        check_val("rst1_res", 32'(result), 32'd0);
        check_val("rst1_cy",  32'(carry_out), 32'd0);
        @(posedge clk);
        #1;
        check_val("rst2_res", 32'(result), 32'd0);
        check_val("rst2_cy",  32'(carry_out), 32'd0);
        rst = 1'b0;
        apply("rel_add", 4'hF, 4'hF, OP_ADD, 14, 1);

        apply("add_5_3",   4'd5,    4'd3,    OP_ADD, 8, 0);
        apply("add_9_8",   4'd9,    4'd8,    OP_ADD, 1, 1);
        apply("add_f_1",   4'hF,    4'h1,    OP_ADD, 0, 1);
        apply("sub_7_3",   4'd7,    4'd3,    OP_SUB, 4, 0);
        apply("sub_3_5",   4'd3,    4'd5,    OP_SUB, 14, 1);
        apply("sub_eq",    4'd6,    4'd6,    OP_SUB, 0, 0);
        apply("sub_0_1",   4'd0,    4'd1,    OP_SUB, 15, 1);
        apply("and",       4'b1010, 4'b1100, OP_AND, 8, 0);
        apply("or",        4'b1010, 4'b1100, OP_OR,  14, 0);
        apply("xor",       4'b1010, 4'b1100, OP_XOR, 6, 0);
        apply("not",       4'b1010, 4'b1100, OP_NOT, 5, 0);
        apply("shl",       4'b1010, 4'b0110, OP_SHL, 4, 1);
        apply("shr",       4'b1010, 4'b0111, OP_SHR, 5, 0);
        apply("shr_1",     4'b0001, 4'b1111, OP_SHR, 0, 1);
        apply("not_bx",    4'b0011, 4'bxxxx, OP_NOT, 12, 0);

        // Mid-stream reset must override the opcode in that cycle.
        rst = 1'b1;
        apply("rst_mid",   4'hF,    4'hF,    OP_ADD, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom_range(0, MOD - 1));
            rb  = W'($urandom_range(0, MOD - 1));
            rop = OP_W'($urandom_range(0, 7));
            ref_model(int'(ra), int'(rb), int'(rop), er, ec);
            apply($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop, er, ec);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_behavioral_alu
